// File: rtl/debounce_pulse_array.sv
// debounce_pulse_array
//   N independent channels. Each channel synchronises a raw asynchronous input,
//   debounces it with a stability counter and emits single-cycle pulses on the
//   rising edge, the falling edge, both edges, or rising edge plus keyboard-style
//   auto-repeat while the input is held.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   in_raw     [N] raw asynchronous inputs, bit i = channel i
//   mode       [2] pulse mode shared by all channels:
//                  00 rise, 01 fall, 10 both edges, 11 rise + auto-repeat
//   enable     1 = pulses allowed; 0 = pulses forced low (debounce keeps running)
//   level      [N] debounced level per channel
//   pulse      [N] registered one-cycle pulse per channel
//   any_pulse  OR of all pulse bits
module debounce_pulse_array #(
    parameter int N             = 4,
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_raw,
    input  logic [1:0]   mode,
    input  logic         enable,
    output logic [N-1:0] level,
    output logic [N-1:0] pulse,
    output logic         any_pulse
);

    localparam int CW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [CW-1:0] CNT_LAST    = CW'(DB_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        MODE_RISE   = 2'b00,
        MODE_FALL   = 2'b01,
        MODE_BOTH   = 2'b10,
        MODE_REPEAT = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rep_state_e;

    // Two-flop synchroniser; only sync2 is used downstream.
    logic [N-1:0] sync1;
    logic [N-1:0] sync2;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its source; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic          lvl;
        logic          flip;
        logic          rise;
        logic          fall;
        logic          edge_fire;
        rep_state_e    state;
        rep_state_e    state_nxt;
        logic [RW-1:0] rc;
        logic [RW-1:0] rc_nxt;
        logic          rep_fire;
        logic          pulse_q;

        // The level flips only after DB_CYCLES consecutive differing samples.
        assign flip = (sync2[i] != lvl) && (cnt == CNT_LAST);
        assign rise = flip && sync2[i];
        assign fall = flip && !sync2[i];

        assign edge_fire = (rise && (mode != MODE_FALL)) ||
                           (fall && ((mode == MODE_FALL) || (mode == MODE_BOTH)));

        // Any sample equal to the current level restarts the stability count.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (sync2[i] == lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                lvl <= sync2[i];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= IDLE;
                rc    <= '0;
            end else begin
                state <= state_nxt;
                rc    <= rc_nxt;
            end
        end

        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a latch behind.
        always_comb begin
            state_nxt = state;
            rc_nxt    = rc;
            rep_fire  = 1'b0;
            if (!enable || (mode != MODE_REPEAT)) begin
                // Leaving repeat mode or disabling pulses drops any pending repeat.
                state_nxt = IDLE;
                rc_nxt    = '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state_nxt = DELAY;
                            rc_nxt    = '0;
                        end
                    end
                    DELAY: begin
                        if (fall) begin
                            state_nxt = IDLE;
                            rc_nxt    = '0;
                        end else if (lvl) begin
                            if (rc == DELAY_LAST) begin
                                rep_fire  = 1'b1;
                                rc_nxt    = '0;
                                state_nxt = REPEAT;
                            end else begin
                                rc_nxt = rc + 1'b1;
                            end
                        end
                    end
                    REPEAT: begin
                        if (fall) begin
                            state_nxt = IDLE;
                            rc_nxt    = '0;
                        end else if (rc == PERIOD_LAST) begin
                            rep_fire = 1'b1;
                            rc_nxt   = '0;
                        end else begin
                            rc_nxt = rc + 1'b1;
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                        rc_nxt    = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= enable && (edge_fire || rep_fire);
            end
        end

        assign level[i] = lvl;
        assign pulse[i] = pulse_q;
    end

    assign any_pulse = |pulse;

endmodule
